pipe_mem_arbiter: RTL

- Arbitrates one single-port unified RAM between the instruction-fetch stage (read-only) and the MEM stage (read/write) of the 16-bit pipeline.
- Sequences each RAM access through a small FSM with a fixed RAM read latency.
- Returns registered data with a one-cycle ack pulse to the granted requester.
- Drives the per-stage stall signals that freeze IF/IFID and EXEMEM while a requester waits.

---
 rtl/pipe_mem_arbiter_if.sv | 37 +++
 rtl/pipe_mem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter_if.sv
// Interface bundling the fetch, MEM-stage and RAM sides of pipe_mem_arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the RAM.
interface pipe_mem_arbiter_if #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13
);
  logic                        if_req;
  logic [MEMORY_ADDR_SIZE-1:0] if_addr;
  logic                        if_ack;
  logic [ARQ-1:0]              if_rdata;
  logic                        if_stall;
  logic                        mem_req;
  logic                        mem_we;
  logic [MEMORY_ADDR_SIZE-1:0] mem_addr;
  logic [ARQ-1:0]              mem_wdata;
  logic                        mem_ack;
  logic [ARQ-1:0]              mem_rdata;
  logic                        mem_stall;
  logic                        ram_en;
  logic                        ram_we;
  logic [MEMORY_ADDR_SIZE-1:0] ram_addr;
  logic [ARQ-1:0]              ram_wdata;
  logic [ARQ-1:0]              ram_rdata;
  logic                        busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_ack, if_rdata, if_stall, mem_ack, mem_rdata, mem_stall,
    output ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_ack, if_rdata, if_stall, mem_ack, mem_rdata, mem_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM stage.
// When the macro PIPE_ARB_RR_EN is defined, contended grants use round-robin; otherwise MEM has fixed priority.
//
// state | meaning
// IDLE  | arbitrate and latch the winner's address/we/wdata
// ISSUE | ram_en strobe for one cycle
// WAIT  | count RD_LAT cycles, then capture ram_rdata
// ACK   | one-cycle ack to the granted port
module pipe_mem_arbiter #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int RD_LAT           = 2
) (
  input logic              clk,
  input logic              rst,
  pipe_mem_arbiter_if.slave bus
);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                      state_q, state_d;
  logic                        grant_q, grant_d;  // 1 = MEM, 0 = IF
  logic                        pick_mem;
  logic [LAT_W-1:0]            lat_q, lat_d;
  logic                        en_q, en_d;
  logic                        we_q, we_d;
  logic [MEMORY_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ARQ-1:0]              wdata_q, wdata_d;
  logic                        if_ack_q, if_ack_d;
  logic                        mem_ack_q, mem_ack_d;
  logic [ARQ-1:0]              if_rdata_q, if_rdata_d;
  logic [ARQ-1:0]              mem_rdata_q, mem_rdata_d;

`ifdef PIPE_ARB_RR_EN
  logic last_q, last_d;
  always_comb pick_mem = (bus.mem_req && bus.if_req) ? ~last_q : bus.mem_req;
`else
  // MEM holds the older instruction, so it wins contention.
  always_comb pick_mem = bus.mem_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      lat_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef PIPE_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lat_q       <= lat_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef PIPE_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lat_d       = lat_q;
    en_d        = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef PIPE_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          grant_d = pick_mem;
`ifdef PIPE_ARB_RR_EN
          last_d  = pick_mem;
`endif
          en_d    = 1'b1;
          state_d = ISSUE;
          if (pick_mem) begin
            we_d    = bus.mem_we;
            addr_d  = bus.mem_addr;
            wdata_d = bus.mem_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d   = ACK;
          mem_ack_d = grant_q;
          if_ack_d  = ~grant_q;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          state_d   = ACK;
          mem_ack_d = grant_q;
          if_ack_d  = ~grant_q;
          if (grant_q) mem_rdata_d = bus.ram_rdata;
          else         if_rdata_d  = bus.ram_rdata;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_en    = en_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.mem_stall = bus.mem_req & ~mem_ack_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
